// File: rtl/fp_div_pkg.sv
// Shared binary32 field layout, special constants and state/class encodings
// for the divider issue stage.
package fp_div_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int FRAC_MSB = 22;
    localparam int FRAC_LSB = 0;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] INF  = 32'h7F80_0000;
    localparam int          BIAS = 127;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORMAL,
        CLS_INF,
        CLS_NAN
    } op_class_t;

endpackage

// File: rtl/fp_div_issue_if.sv
// Operand/result handshake plus the divider-facing operand and result buses.
interface fp_div_issue_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_overflow;
    logic            out_underflow;
    logic            out_exception;
    logic [XLEN-1:0] div_a;
    logic [XLEN-1:0] div_b;
    logic [XLEN-1:0] div_result;

    modport slave (
        input  in_valid, in_a, in_b, out_ready, div_result,
        output in_ready, out_valid, out_result, out_overflow, out_underflow,
               out_exception, div_a, div_b
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_underflow,
               out_exception, div_a, div_b, div_result
    );
endinterface

// File: rtl/FloatingDivision.sv
// Combinational binary32 divider for normal operand pairs whose quotient is
// known to be in range; mantissa is truncated.
module FloatingDivision #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [23:0] ma;
    logic [23:0] mb;
    logic [47:0] q;
    logic [9:0]  e;
    logic [22:0] mant;
    logic [24:0] unused_bits;

    // Quotient of the two 1.f mantissas lands in (0.5, 2) scaled by 2^24.
    always_comb begin
        ma   = {1'b1, a[22:0]};
        mb   = {1'b1, b[22:0]};
        q    = {ma, 24'd0} / {24'd0, mb};
        mant = q[24] ? q[23:1] : q[22:0];
        e    = {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'd127 - {9'd0, ~q[24]};
        result      = {a[31] ^ b[31], e[7:0], mant};
        unused_bits = {q[47:25], e[9:8]};
    end

endmodule

// File: rtl/fp_classify.sv
// Splits a binary32 operand into fields and classifies it; denormals
// are reported as zero.
module fp_classify
    import fp_div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] op,
    output op_class_t       cls,
    output logic            sign,
    output logic [7:0]      expo,
    output logic [22:0]     frac
);

    always_comb begin
        sign = op[SIGN_BIT];
        expo = op[EXP_MSB:EXP_LSB];
        frac = op[FRAC_MSB:FRAC_LSB];
        if (expo == 8'hFF) begin
            cls = (frac != 23'd0) ? CLS_NAN : CLS_INF;
        end else if (expo == 8'h00) begin
            cls = CLS_ZERO;
        end else begin
            cls = CLS_NORMAL;
        end
    end

endmodule

// File: rtl/fp_div_issue.sv
// Issue and special-case stage in front of FloatingDivision: resolves
// IEEE special cases locally and sequences normal pairs through the divider.
module fp_div_issue
    import fp_div_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DIV_LATENCY = 4
) (
    input logic           clk,
    input logic           rst_n,
    fp_div_issue_if.slave bus
);

    localparam int CW = $clog2(DIV_LATENCY + 1);

    op_class_t   cls_a;
    op_class_t   cls_b;
    logic        sa;
    logic        sb;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [22:0] fa;
    logic [22:0] fb;

    fp_classify #(.XLEN(XLEN)) u_class_a (
        .op   (bus.in_a),
        .cls  (cls_a),
        .sign (sa),
        .expo (ea),
        .frac (fa)
    );

    fp_classify #(.XLEN(XLEN)) u_class_b (
        .op   (bus.in_b),
        .cls  (cls_b),
        .sign (sb),
        .expo (eb),
        .frac (fb)
    );

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] res_q;
    logic            ov_q;
    logic            un_q;
    logic            exc_q;
    logic [XLEN-1:0] div_a_q;
    logic [XLEN-1:0] div_b_q;

    logic            bypass;
    logic [XLEN-1:0] byp_result;
    logic            byp_ov;
    logic            byp_un;
    logic            byp_exc;
    logic            sign;
    logic signed [9:0] e_raw;

    // Special-case resolver; the first matching rule wins.
    always_comb begin
        sign       = sa ^ sb;
        e_raw      = $signed({2'b00, ea}) - $signed({2'b00, eb}) + $signed(10'(BIAS));
        bypass     = 1'b1;
        byp_result = '0;
        byp_ov     = 1'b0;
        byp_un     = 1'b0;
        byp_exc    = 1'b0;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
            (cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
            (cls_a == CLS_INF && cls_b == CLS_INF)) begin
            byp_result = QNAN;
            byp_exc    = 1'b1;
        end else if (cls_a == CLS_NORMAL && cls_b == CLS_ZERO) begin
            byp_result = INF | {sign, 31'd0};
            byp_exc    = 1'b1;
        end else if (cls_a == CLS_INF) begin
            byp_result = INF | {sign, 31'd0};
        end else if (cls_a == CLS_ZERO || cls_b == CLS_INF) begin
            byp_result = {sign, 31'd0};
        end else if (e_raw > 10'sd255 || (e_raw == 10'sd255 && fa >= fb)) begin
            byp_result = INF | {sign, 31'd0};
            byp_ov     = 1'b1;
        end else if (e_raw < 10'sd1 || (e_raw == 10'sd1 && fa < fb)) begin
            byp_result = {sign, 31'd0};
            byp_un     = 1'b1;
        end else begin
            bypass = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            res_q   <= '0;
            ov_q    <= 1'b0;
            un_q    <= 1'b0;
            exc_q   <= 1'b0;
            div_a_q <= '0;
            div_b_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bypass) begin
                            res_q <= byp_result;
                            ov_q  <= byp_ov;
                            un_q  <= byp_un;
                            exc_q <= byp_exc;
                            state <= DONE;
                        end else begin
                            div_a_q <= bus.in_a;
                            div_b_q <= bus.in_b;
                            cnt     <= CW'(DIV_LATENCY);
                            state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == CW'(1)) begin
                        res_q <= bus.div_result;
                        ov_q  <= 1'b0;
                        un_q  <= 1'b0;
                        exc_q <= 1'b0;
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready      = (state == IDLE);
    assign bus.out_valid     = (state == DONE);
    assign bus.out_result    = res_q;
    assign bus.out_overflow  = ov_q;
    assign bus.out_underflow = un_q;
    assign bus.out_exception = exc_q;
    assign bus.div_a         = div_a_q;
    assign bus.div_b         = div_b_q;

endmodule

// File: tb/tb_fp_div_issue.sv
// Scoreboard bench for fp_div_issue driving FloatingDivision on the divider bus.
module tb_fp_div_issue;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flags;
        int          lat;
        logic        approx;
    } expect_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        expect_t     e;
    } case_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    expect_t sb[$];
    case_t   cases[$];

    fp_div_issue_if #(.XLEN(32)) bus ();

    fp_div_issue #(.XLEN(32), .DIV_LATENCY(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    FloatingDivision #(.XLEN(32)) u_div (
        .a      (bus.div_a),
        .b      (bus.div_b),
        .result (bus.div_result)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic expect_t mkExp(input logic [31:0] res, input logic [2:0] flags, input int lat, input logic approx);
        expect_t e;
        e.res = res;
        e.flags = flags;
        e.lat = lat;
        e.approx = approx;
        return e;
    endfunction

    function automatic void addCase(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                                    input logic [2:0] flags, input int lat, input logic approx);
        case_t c;
        c.a = a;
        c.b = b;
        c.e = mkExp(res, flags, lat, approx);
        cases.push_back(c);
    endfunction

    // Drives one pair, pushes its expectation at the accept edge, returns #1 after it.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input expect_t e);
        int guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        @(posedge clk);
        sb.push_back(e);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic collectResult(input string tag);
        expect_t e;
        int waited = 0;
        logic signed [32:0] diff;
        while (!bus.out_valid && waited < 20) begin
            checkOutput({tag, "_busy_ready"}, 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        e = sb.pop_front();
        checkOutput({tag, "_latency"}, 32'(waited), 32'(e.lat));
        if (e.approx) begin
            diff = $signed({1'b0, bus.out_result}) - $signed({1'b0, e.res});
            checkOutput({tag, "_result_ulp"}, 32'(diff >= -33'sd1 && diff <= 33'sd1), 32'd1);
            checkOutput({tag, "_result_div"}, bus.out_result, bus.div_result);
        end else begin
            checkOutput({tag, "_result"}, bus.out_result, e.res);
        end
        checkOutput({tag, "_flags"}, 32'({bus.out_overflow, bus.out_underflow, bus.out_exception}), 32'(e.flags));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput({tag, "_release"}, 32'({bus.out_valid, bus.in_ready}), 32'b01);
    endtask

    initial begin
        expect_t e;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.out_ready = 1'b0;

        #3;
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_out_result", bus.out_result, 32'd0);
        checkOutput("reset_flags", 32'({bus.out_overflow, bus.out_underflow, bus.out_exception}), 32'd0);
        checkOutput("reset_div_a", bus.div_a, 32'd0);
        checkOutput("reset_div_b", bus.div_b, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // flags are {overflow, underflow, exception}; lat = edges after accept edge
        addCase(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 3'b001, 0, 1'b0);
        addCase(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b001, 0, 1'b0);
        addCase(32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b001, 0, 1'b0);
        addCase(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 3'b001, 0, 1'b0);
        addCase(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 3'b001, 0, 1'b0);
        addCase(32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 3'b000, 0, 1'b0);
        addCase(32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000, 3'b000, 0, 1'b0);
        addCase(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 3'b000, 0, 1'b0);
        addCase(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 3'b100, 0, 1'b0);
        addCase(32'h7F00_0000, 32'h3F00_0000, 32'h7F80_0000, 3'b100, 0, 1'b0);
        addCase(32'h0080_0000, 32'h3FC0_0000, 32'h0000_0000, 3'b010, 0, 1'b0);
        addCase(32'h8080_0000, 32'h4000_0000, 32'h8000_0000, 3'b010, 0, 1'b0);
        addCase(32'hC0CC_CCCC, 32'hBF00_0000, 32'h414C_CCCC, 3'b000, 4, 1'b1);
        addCase(32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 3'b000, 4, 1'b0);
        addCase(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3'b000, 4, 1'b0);

        foreach (cases[i]) begin
            applyStimulus(cases[i].a, cases[i].b, cases[i].e);
            if (cases[i].e.lat > 0) begin
                checkOutput($sformatf("case%0d_div_a", i), bus.div_a, cases[i].a);
                checkOutput($sformatf("case%0d_div_b", i), bus.div_b, cases[i].b);
            end
            collectResult($sformatf("case%0d", i));
        end

        // Backpressure: result held while a new pair waits on in_valid.
        applyStimulus(32'h3F80_0000, 32'h0000_0000, mkExp(32'h7F80_0000, 3'b001, 0, 1'b0));
        e = sb.pop_front();
        checkOutput("bp_valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_a = 32'h4080_0000;
        bus.in_b = 32'h4000_0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_result", bus.out_result, e.res);
            checkOutput("bp_flags", 32'({bus.out_overflow, bus.out_underflow, bus.out_exception}), 32'(e.flags));
            checkOutput("bp_ready_valid", 32'({bus.in_ready, bus.out_valid}), 32'b01);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput("bp_release", 32'({bus.out_valid, bus.in_ready}), 32'b01);
        @(posedge clk);
        sb.push_back(mkExp(32'h4000_0000, 3'b000, 4, 1'b0));
        #1;
        bus.in_valid = 1'b0;
        collectResult("bp_next");

        // Reset in the second WAIT cycle discards the transaction.
        applyStimulus(32'h4080_0000, 32'h4000_0000, mkExp(32'h4000_0000, 3'b000, 4, 1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_wait_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_wait_out_valid", 32'(bus.out_valid), 32'd0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_no_output", 32'({bus.out_valid, bus.in_ready}), 32'b01);
        end
        checkOutput("rst_result_cleared", bus.out_result, 32'd0);

        applyStimulus(32'h4080_0000, 32'h4000_0000, mkExp(32'h4000_0000, 3'b000, 4, 1'b0));
        collectResult("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
